// File: rtl/game_status_fsm.sv
// game_status_fsm
//   Top-level game controller for the stickman runner. Walks the game through
//   WAIT -> PLAY -> WIN/LOSE -> WAIT, keeps the round score, and emits a
//   one-cycle re-initialisation pulse to the object modules at round start.
//
//   Optional feature macro: GAME_TIMEOUT_EN
//     defined   : per-round frame countdown on time_left; reaching 0 loses.
//     undefined : time_left tied to 0, TIME_LIMIT unused.
//
// Ports
//   Clk        in   system clock, rising-edge
//   Reset_n    in   synchronous active-low reset
//   frame_clk  in   VGA vsync (async to Clk); rising edge = new frame
//   keycode    in   [7:0] current HID keycode, 0 = no key
//   coin_hit   in   one-Clk pulse per coin collected
//   is_dead    in   level, stickman fell or collided
//   status     out  [3:0] one-hot {waiting, playing, win, lose}
//   score      out  [7:0] coins this round, saturating at 255
//   game_rst   out  one-cycle pulse on the first PLAY cycle
//   time_left  out  [11:0] frames remaining in the round
module game_status_fsm #(
  parameter int unsigned WIN_SCORE   = 10,
  parameter int unsigned HOLD_FRAMES = 60,
  parameter logic [7:0]  START_KEY   = 8'h2C,
  parameter int unsigned TIME_LIMIT  = 3600
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        frame_clk,
  input  logic [7:0]  keycode,
  input  logic        coin_hit,
  input  logic        is_dead,
  output logic [3:0]  status,
  output logic [7:0]  score,
  output logic        game_rst,
  output logic [11:0] time_left
);

  if (WIN_SCORE < 1 || WIN_SCORE > 255) begin : g_bad_win_score
    $error("WIN_SCORE out of range 1..255");
  end
  if (HOLD_FRAMES < 1 || HOLD_FRAMES > 255) begin : g_bad_hold_frames
    $error("HOLD_FRAMES out of range 1..255");
  end
  if (TIME_LIMIT < 1 || TIME_LIMIT > 4095) begin : g_bad_time_limit
    $error("TIME_LIMIT out of range 1..4095");
  end

  localparam logic [7:0] WIN_L  = 8'(WIN_SCORE);
  localparam logic [7:0] HOLD_L = 8'(HOLD_FRAMES);
`ifdef GAME_TIMEOUT_EN
  localparam logic [11:0] TLIM_L = 12'(TIME_LIMIT);
`endif

  // State codes double as the one-hot status value, so status is the flop.
  typedef enum logic [3:0] {
    S_WAIT = 4'b1000,
    S_PLAY = 4'b0100,
    S_WIN  = 4'b0010,
    S_LOSE = 4'b0001
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  score_q, score_d;
  logic        game_rst_q, game_rst_d;
  logic [11:0] time_left_q, time_left_d;
  logic [7:0]  hold_q, hold_d;
  logic        armed_q, armed_d;
  logic        fsync1_q, fsync2_q, fedge_q;

  logic        frame_tick;
  logic        start_ok;
  logic        timeout;
  logic [7:0]  score_inc;

  always_comb begin
    frame_tick  = fsync2_q & ~fedge_q;
    start_ok    = armed_q && (keycode == START_KEY);
    score_inc   = (score_q == 8'hFF) ? score_q : score_q + 8'd1;

    state_d     = state_q;
    score_d     = score_q;
    game_rst_d  = 1'b0;
    time_left_d = time_left_q;
    hold_d      = hold_q;
    timeout     = 1'b0;
    // Armed latches high once the start key is seen released.
    armed_d     = armed_q | (keycode != START_KEY);

`ifdef GAME_TIMEOUT_EN
    if (state_q == S_PLAY && frame_tick) begin
      timeout = (time_left_q == 12'd1);
      if (time_left_q != '0) begin
        time_left_d = time_left_q - 12'd1;
      end
    end
`else
    time_left_d = '0;
`endif

    case (state_q)
      S_WAIT: begin
        if (start_ok) begin
          state_d    = S_PLAY;
          score_d    = '0;
          game_rst_d = 1'b1;
`ifdef GAME_TIMEOUT_EN
          time_left_d = TLIM_L;
`endif
        end
      end
      S_PLAY: begin
        if (is_dead) begin
          state_d = S_LOSE;
        end else if (timeout) begin
          state_d = S_LOSE;
        end else if (coin_hit) begin
          score_d = score_inc;
          if (score_inc >= WIN_L) begin
            state_d = S_WIN;
          end
        end
      end
      S_WIN, S_LOSE: begin
        if (hold_q == HOLD_L && start_ok) begin
          state_d = S_WAIT;
        end else if (frame_tick && hold_q < HOLD_L) begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: state_d = S_WAIT;
    endcase

    // Any transition disarms; entering an end state restarts the hold count.
    if (state_d != state_q) begin
      armed_d = 1'b0;
      if (state_d == S_WIN || state_d == S_LOSE) begin
        hold_d = '0;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q     <= S_WAIT;
      score_q     <= '0;
      game_rst_q  <= 1'b0;
      time_left_q <= '0;
      hold_q      <= '0;
      armed_q     <= 1'b0;
      fsync1_q    <= 1'b0;
      fsync2_q    <= 1'b0;
      fedge_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      score_q     <= score_d;
      game_rst_q  <= game_rst_d;
      time_left_q <= time_left_d;
      hold_q      <= hold_d;
      armed_q     <= armed_d;
      fsync1_q    <= frame_clk;
      fsync2_q    <= fsync1_q;
      fedge_q     <= fsync2_q;
    end
  end

  assign status    = state_q;
  assign score     = score_q;
  assign game_rst  = game_rst_q;
  assign time_left = time_left_q;

endmodule

// File: tb/tb_game_status_fsm.sv
module tb_game_status_fsm;
  localparam int unsigned WS = 3;
  localparam int unsigned HF = 8;
  localparam int unsigned TL = 5;
  localparam logic [7:0]  SK = 8'h2C;
`ifdef GAME_TIMEOUT_EN
  localparam int unsigned EXP_TL0 = TL;
`else
  localparam int unsigned EXP_TL0 = 0;
`endif

  logic        Clk = 1'b0;
  logic        Reset_n, frame_clk, coin_hit, is_dead;
  logic [7:0]  keycode;
  logic [3:0]  status;
  logic [7:0]  score;
  logic        game_rst;
  logic [11:0] time_left;

  int total = 0;
  int bad   = 0;

  always #5 Clk = ~Clk;

  game_status_fsm #(
    .WIN_SCORE(WS), .HOLD_FRAMES(HF), .START_KEY(SK), .TIME_LIMIT(TL)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .keycode(keycode),
    .coin_hit(coin_hit), .is_dead(is_dead), .status(status), .score(score),
    .game_rst(game_rst), .time_left(time_left)
  );

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  // Behavioural model: mode 0=WAIT 1=PLAY 2=WIN 3=LOSE, status = 4'b1000 >> mode.
  int  m_mode = 0, m_score = 0, m_hold = 0, m_tl = 0;
  bit  m_armed = 0, m_rst = 0, started = 0;
  bit  fcs[$] = '{0, 0, 0};  // fcs[k] = frame_clk sampled k+1 edges ago

  always @(posedge Clk) begin : model
    bit tick, start, to;
    int nmode;
    if (!Reset_n) begin
      m_mode = 0; m_score = 0; m_hold = 0; m_tl = 0;
      m_armed = 0; m_rst = 0;
      fcs = '{0, 0, 0};
    end else begin
      // A frame edge seen two edges ago (and low the edge before) ticks now.
      tick  = fcs[1] && !fcs[2];
      fcs.push_front(frame_clk);
      void'(fcs.pop_back());
      start = m_armed && (keycode == SK);
      nmode = m_mode;
      m_rst = 0;
      to    = 0;
      if (m_mode == 0) begin
        if (start) begin
          nmode = 1; m_score = 0; m_rst = 1; m_tl = EXP_TL0;
        end
      end else if (m_mode == 1) begin
`ifdef GAME_TIMEOUT_EN
        to = tick && (m_tl == 1);
        if (tick && m_tl > 0) m_tl = m_tl - 1;
`endif
        if (is_dead || to) nmode = 3;
        else if (coin_hit) begin
          if (m_score < 255) m_score = m_score + 1;
          if (m_score >= WS) nmode = 2;
        end
      end else begin
        if (m_hold == HF && start) nmode = 0;
        else if (tick && m_hold < HF) m_hold = m_hold + 1;
      end
      if (nmode != m_mode) begin
        m_armed = 0;
        if (nmode >= 2) m_hold = 0;
      end else if (keycode != SK) begin
        m_armed = 1;
      end
      m_mode = nmode;
    end
    started = 1;
  end

  always @(negedge Clk) begin
    if (started) begin
      check("status",    32'(status),    32'(4'b1000 >> m_mode));
      check("score",     32'(score),     32'(m_score));
      check("game_rst",  32'(game_rst),  32'(m_rst));
      check("time_left", 32'(time_left), 32'(m_tl));
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge Clk);
      @(negedge Clk);
    end
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      frame_clk = 1'b1; step(4);
      frame_clk = 1'b0; step(4);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, half;
    Reset_n = 0; keycode = 0; coin_hit = 0; is_dead = 0; frame_clk = 0;
    @(negedge Clk);
    step(2);
    check("rst_status", 32'(status), 32'h8);
    check("rst_score", 32'(score), 0);
    check("rst_game_rst", 32'(game_rst), 0);
    check("rst_time_left", 32'(time_left), 0);

    Reset_n = 1; step(1);
    keycode = SK; step(1);
    check("start_status", 32'(status), 32'h4);
    check("start_game_rst", 32'(game_rst), 1);
    check("start_time_left", 32'(time_left), 32'(EXP_TL0));
    step(1);
    check("start_rst_width", 32'(game_rst), 0);

    keycode = 0; coin_hit = 1;
    step(1); check("coin1", 32'(score), 1);
    step(1); check("coin2", 32'(score), 2);
    check("coin2_status", 32'(status), 32'h4);
    step(1); check("coin3", 32'(score), 3);
    check("win_status", 32'(status), 32'h2);
    step(1); check("coin4_ignored", 32'(score), 3);
    coin_hit = 0;

    frames(HF);
    keycode = SK; step(1);
    check("win_to_wait", 32'(status), 32'h8);
    check("score_held", 32'(score), 3);
    keycode = 0; step(1); keycode = SK; step(1);
    check("replay", 32'(status), 32'h4);
    check("replay_score", 32'(score), 0);
    keycode = 0;

    coin_hit = 1; step(1); coin_hit = 0;
    is_dead = 1; coin_hit = 1; step(1);
    check("dead_status", 32'(status), 32'h1);
    check("dead_score", 32'(score), 1);
    is_dead = 0; coin_hit = 0;

    keycode = SK; frames(HF); step(4);
    check("held_key_lose", 32'(status), 32'h1);
    keycode = 0; step(1); keycode = SK; step(1);
    check("lose_to_wait", 32'(status), 32'h8);
    step(5);
    check("no_chain", 32'(status), 32'h8);
    keycode = 0; step(1); keycode = SK; step(1);
    check("rearm_play", 32'(status), 32'h4);
    keycode = 0;

    coin_hit = 1; step(2); coin_hit = 0;
    check("mid_score", 32'(score), 2);
    Reset_n = 0; step(1);
    check("mid_rst_status", 32'(status), 32'h8);
    check("mid_rst_score", 32'(score), 0);
    check("mid_rst_tl", 32'(time_left), 0);
    Reset_n = 1; step(1);

`ifdef GAME_TIMEOUT_EN
    keycode = SK; step(1);
    check("to_start_tl", 32'(time_left), 5);
    keycode = 0;
    frames(4);
    check("to_tl1", 32'(time_left), 1);
    check("to_still_play", 32'(status), 32'h4);
    frames(1);
    check("to_tl0", 32'(time_left), 0);
    check("to_lose", 32'(status), 32'h1);
    frames(HF);
    keycode = SK; step(1); keycode = 0; step(1); keycode = SK; step(1);
    keycode = 0;
    coin_hit = 1; step(1); coin_hit = 0;
    frames(4);
    frame_clk = 1; step(2);
    is_dead = 1; step(1);
    check("to_dead_status", 32'(status), 32'h1);
    check("to_dead_score", 32'(score), 1);
    is_dead = 0; frame_clk = 0; step(4);
`endif

    cnt = 0; half = 4;
    for (int i = 0; i < 15000; i++) begin
      Reset_n = ($urandom_range(0, 999) != 0);
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 3))
          0:       keycode = 8'h00;
          1, 2:    keycode = SK;
          default: keycode = 8'h04;
        endcase
      end
      coin_hit = ($urandom_range(0, 2) == 0);
      is_dead  = ($urandom_range(0, 24) == 0);
      cnt++;
      if (cnt >= half) begin
        frame_clk = ~frame_clk;
        cnt = 0;
        half = $urandom_range(3, 6);
      end
      step(1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/game_status_fsm.md
# game_status_fsm

Top-level game controller for the stickman runner. It produces the one-hot `status` vector and the score that the colour mapper and the score display consume. It advances the game through the waiting, playing, win and lose states, driven by:
- keyboard input;
- coin-collection events;
- death events;
- the per-frame vertical sync.

It sits between the keycode/collision logic and the rendering path, and emits a one-cycle reset pulse to the object modules at the start of each round.

## Interface
Parameters:
- `WIN_SCORE`, default 10: coins needed to win; legal range 1..255.
- `HOLD_FRAMES`, default 60: frames that WIN/LOSE are held before a key is accepted; legal range 1..255.
- `START_KEY`, default 8'h2C: HID keycode (space) that starts or acknowledges a round.
- `TIME_LIMIT`, default 3600: frames per round; only used with the timeout feature; legal range 1..4095.

Ports (one clock; reset is synchronous and active-low):
- `Clk`  in  1  system clock; all state changes on its rising edge.
- `Reset_n`  in  1  synchronous active-low reset.
- `frame_clk`  in  1  VGA vertical sync, asynchronous to `Clk`; its rising edge marks a new frame.
- `keycode`  in  8  current keyboard keycode; 0 when no key is pressed.
- `coin_hit`  in  1  one-`Clk` pulse per coin collected.
- `is_dead`  in  1  level; stickman has fallen or collided.
- `status`  out  4  one-hot {waiting, playing, win, lose}.
- `score`  out  8  coins collected this round.
- `game_rst`  out  1  one-cycle pulse; re-initialises the stickman, coins and ground.
- `time_left`  out  12  frames remaining in the round.

## Operation
- **Frame tick.** `frame_clk` passes through a 2-flop synchroniser plus an edge-detect register. This produces `frame_tick`, one `Clk` wide per rising edge.
- **Armed flag.**
  - Set in any cycle where `keycode != START_KEY`.
  - Cleared on every state transition.
  - A `START_KEY` transition requires the flag to be set, so holding the key never chains transitions.
- **States and `status` encoding:** WAIT = 4'b1000, PLAY = 4'b0100, WIN = 4'b0010, LOSE = 4'b0001. No other encoding is ever driven.
- **WAIT.** On `keycode == START_KEY` with armed set:
  - go to PLAY;
  - `score` <= 0;
  - `time_left` <= `TIME_LIMIT`;
  - `game_rst` <= 1 for one cycle.
- **PLAY.** Priority per cycle, highest first:
  1. `is_dead` → LOSE. A `coin_hit` in the same cycle is ignored.
  2. Timeout → LOSE (only with the timeout feature).
  3. `coin_hit` → `score` <= `score` + 1. If the new score is ≥ `WIN_SCORE`, go to WIN in the same edge.
- **Score width.** `score` saturates at 255. It is only cleared on entry to PLAY, so it is held through WIN, LOSE and WAIT.
- **WIN / LOSE.**
  - The 8-bit hold counter is cleared on entry.
  - It increments on each `frame_tick` until it reaches `HOLD_FRAMES`.
  - Once it equals `HOLD_FRAMES` and armed is set, `START_KEY` → WAIT.
  - `coin_hit` and `is_dead` are ignored in these states.
- **Reset.** `Reset_n` = 0 at a clock edge forces, regardless of state (including mid-round):
  - `status` = 4'b1000, `score` = 0, `game_rst` = 0, `time_left` = 0;
  - hold counter = 0, armed = 0;
  - synchroniser flops = 0.

## Timing
- All outputs are registered.
- A qualifying input sampled at edge n is reflected on the outputs after edge n.
- `game_rst` is high during exactly the first cycle in which `status` reads PLAY.
- `frame_clk` rising edge to `frame_tick`: 2-3 `Clk` cycles; no frame is lost if the frame period exceeds 4 `Clk`.
- Coin → WIN: the edge that samples the winning `coin_hit` updates `score` and `status` together.
- Back-to-back `coin_hit` pulses on consecutive cycles each count.

## Configuration
- **`GAME_TIMEOUT_EN` defined:**
  - In PLAY, each `frame_tick` decrements `time_left`.
  - A tick that moves `time_left` from 1 to 0 forces LOSE at that same edge.
  - `is_dead` outranks the timeout; the timeout outranks a winning coin in the same cycle.
  - `time_left` freezes outside PLAY.
- **`GAME_TIMEOUT_EN` not defined:**
  - `time_left` is tied to 0.
  - `TIME_LIMIT` is unused.
  - A round ends only by win or death.

## Test plan
- **Reset and start.** Hold `Reset_n` = 0 for 2 cycles, then release. Expect `status` = 1000 and `score` = 0. With `keycode` = 8'h00 for 1 cycle then 8'h2C, expect `status` = 0100 and a one-cycle `game_rst` at that same edge.
- **Win path.** With `WIN_SCORE` = 3, send 3 `coin_hit` pulses on consecutive cycles. Expect `score` 1, 2, 3; `status` = 0010 at the edge that makes `score` 3; a 4th pulse leaves `score` = 3.
- **Death priority.** Assert `is_dead` and `coin_hit` in the same cycle while in PLAY. Expect `status` = 0001 and `score` unchanged.
- **Hold and re-arm.**
  - In LOSE, hold `keycode` = 8'h2C continuously through 60 frame ticks: expect the state to remain LOSE.
  - Release to 0 for 1 cycle, then press again: expect WAIT.
  - Hold the key: PLAY is not entered until the key is released and pressed again.
- **Timeout (`GAME_TIMEOUT_EN`, `TIME_LIMIT` = 5).** Give 5 frame ticks with no coins. Expect `time_left` 5→0 and LOSE on the 5th tick. With `is_dead` also asserted at the 5th tick, expect LOSE with `score` unchanged.
- **Reset mid-round.** In PLAY with `score` = 2, pulse `Reset_n` low for 1 cycle. Expect `status` = 1000, `score` = 0 and `time_left` = 0 on the next cycle.
